// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1-style UART receiver with mid-bit sampling and valid/ready out
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int HALF        = PULSE_WIDTH / 2;
  localparam int CW          = $clog2(PULSE_WIDTH);
  localparam int IW          = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_WIDTH - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shift;
  logic                  sig_m;
  logic                  sig_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
      sig_m     <= 1'b1;
      sig_s     <= 1'b1;
    end else begin
      sig_m     <= sig;
      sig_s     <= sig_m;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // A consumed word drops valid unless a new frame reloads it below.
      if (valid && ready) valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!sig_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!sig_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shift[idx] <= sig_s;
            if (idx == IDX_LAST) state <= STOP;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (sig_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!valid || ready) begin
                data  <= shift;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Hold off until the line returns high so a break is not re-framed.
        WAIT_IDLE: begin
          if (sig_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed self-checking bench for uart_rx at 16 clocks per bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int DW = 8;
  localparam int PW = 16;

  logic          clk;
  logic          rst;
  logic          sig;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DW-1:0] rxq[$];
  int vcyc  = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int bfall = 0;
  logic prev_busy = 1'b0;

  uart_rx #(
    .DATA_WIDTH (DW),
    .BAUD_RATE  (100_000),
    .CLK_FREQ   (1_600_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe pre-edge values: a word is taken exactly when valid&&ready at posedge.
  always @(posedge clk) begin
    if (valid && ready) rxq.push_back(data);
    if (valid)          vcyc   <= vcyc + 1;
    if (frame_err)      fe_cnt <= fe_cnt + 1;
    if (overrun)        ov_cnt <= ov_cnt + 1;
    if (prev_busy && !busy) bfall <= bfall + 1;
    prev_busy <= busy;
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic stop_bit);
    sig = 1'b0;
    repeat (PW) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      sig = d[i];
      repeat (PW) @(negedge clk);
    end
    sig = stop_bit;
    repeat (PW) @(negedge clk);
  endtask

  function automatic logic [DW-1:0] last_rx();
    return (rxq.size() > 0) ? rxq[rxq.size()-1] : 8'hxx;
  endfunction

  initial begin
    int b_v, b_fe, b_ov, b_bf, b_q;

    rst = 1'b1; sig = 1'b0; ready = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0; sig = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_valid", valid, 0);
    check("idle_busy", busy, 0);
    check("idle_vcyc", vcyc, 0);

    // Back-to-back sweep of every byte value
    ready = 1'b1;
    b_v = vcyc; b_fe = fe_cnt; b_ov = ov_cnt; b_q = rxq.size();
    for (int i = 0; i < 256; i++) send(DW'(i), 1'b1);
    repeat (2*PW) @(negedge clk);
    check("sweep_count", rxq.size() - b_q, 256);
    check("sweep_vcyc", vcyc - b_v, 256);
    check("sweep_ferr", fe_cnt - b_fe, 0);
    check("sweep_ovr", ov_cnt - b_ov, 0);
    for (int i = 0; i < 256; i++)
      check("sweep_word", (b_q + i < rxq.size()) ? rxq[b_q + i] : 8'hxx, i);

    // Short low pulse must not start a frame
    b_v = vcyc; b_fe = fe_cnt; b_q = rxq.size();
    sig = 1'b0;
    repeat (4) @(negedge clk);
    sig = 1'b1;
    repeat (2*PW) @(negedge clk);
    check("glitch_vcyc", vcyc - b_v, 0);
    check("glitch_ferr", fe_cnt - b_fe, 0);
    check("glitch_busy", busy, 0);
    send(8'h5A, 1'b1);
    repeat (2*PW) @(negedge clk);
    check("glitch_next_cnt", rxq.size() - b_q, 1);
    check("glitch_next_word", last_rx(), 8'h5A);

    // Framing error followed by a break
    b_v = vcyc; b_fe = fe_cnt; b_ov = ov_cnt; b_bf = bfall; b_q = rxq.size();
    send(8'hA5, 1'b0);
    sig = 1'b0;
    repeat (3*PW) @(negedge clk);
    sig = 1'b1;
    repeat (2*PW) @(negedge clk);
    check("ferr_pulses", fe_cnt - b_fe, 1);
    check("ferr_vcyc", vcyc - b_v, 0);
    check("ferr_ovr", ov_cnt - b_ov, 0);
    check("ferr_busy_falls", bfall - b_bf, 1);
    check("ferr_valid", valid, 0);
    send(8'h3C, 1'b1);
    repeat (2*PW) @(negedge clk);
    check("ferr_next_cnt", rxq.size() - b_q, 1);
    check("ferr_next_word", last_rx(), 8'h3C);

    // Overrun: second word dropped while first is pending
    ready = 1'b0;
    b_ov = ov_cnt; b_fe = fe_cnt;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    repeat (2*PW) @(negedge clk);
    check("ovr_valid", valid, 1);
    check("ovr_data", data, 8'h11);
    check("ovr_pulses", ov_cnt - b_ov, 1);
    check("ovr_ferr", fe_cnt - b_fe, 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("ovr_consumed_valid", valid, 0);
    check("ovr_consumed_word", last_rx(), 8'h11);

    // Consume and reload on the same edge
    send(8'h66, 1'b1);
    repeat (2*PW) @(negedge clk);
    check("sim_pending_valid", valid, 1);
    check("sim_pending_data", data, 8'h66);
    b_ov = ov_cnt;
    fork
      send(8'h77, 1'b1);
      begin
        repeat (154) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    check("sim_valid", valid, 1);
    check("sim_data", data, 8'h77);
    check("sim_ovr", ov_cnt - b_ov, 0);
    check("sim_took_old", last_rx(), 8'h66);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    check("sim_took_new", last_rx(), 8'h77);
    check("sim_drained", valid, 0);

    // Reset in the middle of the data bits
    b_v = vcyc; b_fe = fe_cnt; b_q = rxq.size();
    sig = 1'b0;
    repeat (PW) @(negedge clk);
    sig = 1'b1;
    repeat (3*PW) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3*PW) @(negedge clk);
    check("mrst_vcyc", vcyc - b_v, 0);
    check("mrst_ferr", fe_cnt - b_fe, 0);
    check("mrst_busy", busy, 0);
    check("mrst_valid", valid, 0);
    send(8'hC3, 1'b1);
    repeat (2*PW) @(negedge clk);
    check("mrst_next_cnt", rxq.size() - b_q, 1);
    check("mrst_next_word", last_rx(), 8'hC3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
